// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit owning the Hi/Lo registers (shift-add multiply, restoring divide).
// Optional MTHI/MTLO write ports are enabled by defining MULTDIV_MTHILO_EN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef MULTDIV_MTHILO_EN
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_nowr;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_signed;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // Magnitudes are held unsigned, so -(0x80000000) = 2^31 is exact.
  assign w_signed = ~op[0];
  assign w_is_div = op[1];
  assign w_a_neg  = w_signed & a_in[WIDTH-1];
  assign w_b_neg  = w_signed & b_in[WIDTH-1];
  assign w_b_zero = (b_in == '0);
  assign w_a_mag  = w_a_neg ? -a_in : a_in;
  assign w_b_mag  = w_b_neg ? -b_in : b_in;

  logic [WIDTH-1:0]   w_mul_addend;
  logic [WIDTH:0]     w_mul_add;
  logic [2*WIDTH-1:0] w_mul_nx;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  assign w_mul_addend = r_acc[0] ? r_opnd : '0;
  assign w_mul_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_addend};
  assign w_mul_nx     = {w_mul_add, r_acc[WIDTH-1:1]};

  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [2*WIDTH-1:0] w_div_nx;

  // Divide: r_acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_opnd});
  assign w_rem_nx = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_opnd}) : w_rem_sh[WIDTH-1:0];
  assign w_div_nx = {w_rem_nx, r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_hi_res   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_res   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_nowr     <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef MULTDIV_MTHILO_EN
          // A Hi/Lo write takes priority; a coincident start is dropped.
          if (hi_wr || lo_wr) begin
            if (hi_wr) r_hi <= wr_data;
            if (lo_wr) r_lo <= wr_data;
          end else
`endif
          if (start) begin
            r_div_zero <= 1'b0;
            r_busy     <= 1'b1;
            r_is_div   <= w_is_div;
            r_neg_lo   <= w_a_neg ^ w_b_neg;
            r_neg_hi   <= w_a_neg;
            r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_cnt      <= CW'(WIDTH - 1);
            if (w_is_div && w_b_zero) begin
              r_nowr  <= 1'b1;
              r_state <= S_FIX;
            end else begin
              r_nowr  <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_nx : w_mul_nx;
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_nowr) begin
            r_div_zero <= 1'b1;
          end else begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle integer multiply/divide unit for the MIPS multicycle datapath; implements MULT, MULTU, DIV, DIVU.
- Sits directly downstream of the A/B operand registers: it consumes Aout/Bout, owns the architectural Hi/Lo registers and feeds them back to the register-write mux for MFHI/MFLO.
- The Control FSM pulses start and holds its own state until done.

Parameters:
- WIDTH, 32, operand and Hi/Lo width; iteration count equals WIDTH.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=MULT signed, 01=MULTU, 10=DIV signed, 11=DIVU.
- a_in  input  WIDTH  rs operand (multiplicand/dividend).
- b_in  input  WIDTH  rt operand (multiplier/divisor).
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  sticky flag: last DIV/DIVU had b_in=0.
- hi  output  WIDTH  Hi register (product[63:32] / remainder).
- lo  output  WIDTH  Lo register (product[31:0] / quotient).

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, iteration counter=0.
- Reset asserted mid-operation aborts immediately. Hi/Lo go to 0 and no done is produced.
- States: IDLE, RUN, FIX.
- Operand capture (edge N, state IDLE, start=1):
  - Latch op and operand magnitudes. For signed ops, use the absolute value of each operand; abs(0x80000000) = 2^31 held in WIDTH+1 bits.
  - Record the result signs.
  - Counter := WIDTH-1. State := RUN.
  - div_zero is cleared at every accepted start.
- Divide by zero (DIV/DIVU with b_in=0 at edge N): go straight to FIX with a no-write flag. Edge N+1 gives IDLE, done=1, div_zero=1, Hi/Lo unchanged.
- RUN: one iteration per clock.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - At counter=0, the next edge goes to FIX. Otherwise decrement the counter.
- FIX: apply sign correction and write Hi/Lo on the next edge, then return to IDLE with done=1.
- Timing: start accepted at edge N; RUN covers edges N+1..N+32; FIX lasts one cycle; Hi/Lo are valid and done=1 after edge N+33.
  - busy is high from after edge N until edge N+33.
  - Latency is 34 clocks. done is high for exactly one cycle.
- start while busy=1 is ignored; no queueing. start coincident with done (state already IDLE on the next cycle) is accepted normally.
- Operands are sampled only at the capture edge. Changes on a_in/b_in/op during RUN have no effect.
- Multiply result: Hi:Lo = full 64-bit product. Signed product is negated if the operand signs differ.
- Divide result:
  - Lo = quotient, truncated toward zero.
  - Hi = remainder, taking the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. No trap.
- Hi/Lo hold their value indefinitely between operations. They are read combinationally with no read latency.

Optional Feature:
- Macro MULTDIV_MTHILO_EN.
- Defined: adds ports hi_wr (1), lo_wr (1) and wr_data (WIDTH) for MTHI/MTLO.
  - In IDLE, hi_wr/lo_wr write wr_data into hi/lo on the edge. Both may be asserted together.
  - If start and a write coincide, the write is performed and start is ignored that cycle.
  - Writes while busy=1 are ignored.
- Not defined: the ports are absent. Hi/Lo change only through multiply/divide completion or Reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge N: busy=1 for 33 cycles, done=1 after edge N+33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=0x00000007: hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=0x00000002: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2: lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0. DIVU a=5, b=0 with prior hi=0x11, lo=0x22: done after 2 edges, div_zero=1, hi=0x11, lo=0x22 unchanged.
- start pulse at cycle 10 of a running MULT: ignored, with a single done and the original result. Assert Reset at RUN cycle 15: busy=0, done never pulses, hi=lo=0. A new start afterwards completes normally.
- With MULTDIV_MTHILO_EN, in IDLE: hi_wr=1, wr_data=0xCAFEF00D gives hi=0xCAFEF00D next cycle. lo_wr during busy is ignored, and lo shows the operation result.
